tcm_inst_loader: RTL and testbench
==================================

Name: tcm_inst_loader

Overview:
- Upstream feeder for riscv_tcm_top: accepts a stream of 32-bit instruction words and writes them into the TCM through the tb_inst write port at sequential word addresses.
- Classifies each word by opcode and keeps per-class counters.
- After loading, pulses the core reset, then counts execution cycles until the fetch stage presents the halt instruction.
- Replaces the hand-driven load/profile/run sequence with synthesizable control usable on FPGA bring-up and in benches.

Parameters:
- TRACE_SIZE, 200: maximum words loaded per run.
- BASE_ADDR, 32'h0: TCM byte address of word 0.
- CNT_W, 16: width of all counters.
- HALT_INST, 32'h0000_8067: fetch word that ends the run.
- EXEC_OFFSET, 4: pipeline drain added to the halt cycle count.
- MAX_RUN, 65535: run-cycle timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- start_i  in  1  begin a load/run session (level sampled)
- inst_valid_i  in  1  instruction word valid
- inst_data_i  in  32  instruction word
- inst_last_i  in  1  final word of program
- inst_ready_o  out  1  loader accepts word
- tb_inst_we_o  out  4  TCM byte write enables
- tb_inst_addr_o  out  32  TCM byte address
- tb_inst_data_o  out  32  TCM write data
- rst_cpu_o  out  1  core reset pulse
- fetch_inst_i  in  32  instruction currently at fetch (u_fetch icache_inst)
- busy_o  out  1  not IDLE/DONE
- done_o  out  1  in DONE
- timeout_o  out  1  run ended by MAX_RUN
- cnt_alu_o, cnt_load_o, cnt_store_o, cnt_branch_o, cnt_etc_o, cnt_words_o  out  CNT_W each  profile counters
- exec_cycles_o  out  CNT_W  run length

Behaviour:
- One clock; reset is synchronous and active-high; clock port clk_i, reset port rst_i.
- Reset values (also apply on rst_i mid-session, including mid-load and mid-run):
  - state IDLE; all outputs 0; all counters 0.
  - No partial write completes after the reset edge.
- FSM: IDLE -> LOAD -> GAP -> CRST -> RUN -> DONE.
  - IDLE: start_i=1 -> LOAD; counters and word index cleared.
  - LOAD: inst_ready_o=1. Handshake is inst_valid_i & inst_ready_o.
    - On handshake, next cycle for exactly one cycle: tb_inst_we_o=4'hf, tb_inst_addr_o=BASE_ADDR+4*idx, tb_inst_data_o=inst_data_i. Latency 1; back-to-back words give back-to-back writes.
    - Otherwise tb_inst_we_o=0 and addr/data hold their last values.
    - Leave LOAD after the handshake where inst_last_i=1 or idx=TRACE_SIZE-1; inst_ready_o drops in the following cycle.
    - inst_valid_i with ready low is ignored; no data is lost, because the source must hold.
  - GAP: one idle cycle so the last write lands.
  - CRST: rst_cpu_o=1 for exactly one cycle; run counter cleared.
  - RUN: run counter N starts at 0 in the first RUN cycle and increments each cycle.
    - If fetch_inst_i==HALT_INST: exec_cycles_o=N+EXEC_OFFSET, then DONE.
    - Else if N==MAX_RUN: timeout_o=1, exec_cycles_o=MAX_RUN, then DONE.
    - Halt wins over timeout in the same cycle.
  - DONE: outputs and counters held. start_i=1 -> LOAD with counters, timeout_o and exec_cycles_o cleared.
- start_i is ignored outside IDLE/DONE.
- Classification uses inst_data_i[6:0] at handshake:
  - 51 or 19 -> alu
  - 3 -> load
  - 35 -> store
  - 99 -> branch
  - 103, 111, 23, 55 -> etc
  - any other opcode -> no class counter
  - cnt_words_o counts every accepted word.
- All counters saturate at 2^CNT_W-1 and never wrap.
- Word 0 with inst_last_i=1 is a valid one-word program.

Decomposition:
- Package tcm_loader_pkg holds:
  - opcode localparams (OP_R/M 51, OP_I_ARITH 19, OP_LOAD 3, OP_STORE 35, OP_BRANCH 99, OP_JALR 103, OP_JAL 111, OP_AUIPC 23, OP_LUI 55)
  - state enum
  - opcode-class enum plus classify function
- One sub-module, tcm_inst_profiler: combinational class decode plus five saturating counters, enabled by the handshake.
- FSM, write port and run counter stay in the top.

Test Plan:
- 3 words (0x00500093, 0x00302023, 0x00008067), last on the third, continuous valid -> writes at addr 0,4,8 on consecutive cycles. alu=1, store=1, etc=1, words=3. rst_cpu_o high exactly 1 cycle, 2 cycles after the last write.
- Valid toggled 1,0,1 -> exactly 2 writes at 0 and 4. No write in the gap cycle.
- RUN with fetch_inst_i=0x00008067 at N=7 -> exec_cycles_o=11, done_o=1, timeout_o=0.
- TRACE_SIZE=4, 6 words offered, no last -> 4 writes (addresses 0..12). inst_ready_o low after the 4th. words=4.
- MAX_RUN=10, halt never seen -> timeout_o=1, exec_cycles_o=10. Halt seen at N=10 instead -> exec_cycles_o=14, timeout_o=0.
- rst_i asserted during LOAD after 2 words -> next cycle IDLE, all counters 0, tb_inst_we_o=0, rst_cpu_o=0. A new start_i reloads from address BASE_ADDR.

Source files
------------

// File: rtl/tcm_loader_pkg.sv
// Shared opcode constants, FSM states and opcode classes
// for the TCM instruction loader.
package tcm_loader_pkg;

  localparam logic [6:0] OP_RM      = 7'd51;
  localparam logic [6:0] OP_I_ARITH = 7'd19;
  localparam logic [6:0] OP_LOAD    = 7'd3;
  localparam logic [6:0] OP_STORE   = 7'd35;
  localparam logic [6:0] OP_BRANCH  = 7'd99;
  localparam logic [6:0] OP_JALR    = 7'd103;
  localparam logic [6:0] OP_JAL     = 7'd111;
  localparam logic [6:0] OP_AUIPC   = 7'd23;
  localparam logic [6:0] OP_LUI     = 7'd55;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GAP,
    S_CRST,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    CL_NONE,
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_ETC
  } op_class_t;

  function automatic op_class_t classify(
    input logic [6:0] op
  );
    op_class_t c;
    case (op)
      OP_RM, OP_I_ARITH: c = CL_ALU;
      OP_LOAD:           c = CL_LOAD;
      OP_STORE:          c = CL_STORE;
      OP_BRANCH:         c = CL_BRANCH;
      OP_JALR, OP_JAL,
      OP_AUIPC, OP_LUI:  c = CL_ETC;
      default:           c = CL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tcm_inst_profiler.sv
// Per-class instruction counters, all saturating,
// advanced once per accepted instruction word.
module tcm_inst_profiler
  import tcm_loader_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [6:0]       opcode,
  output logic [CNT_W-1:0] cnt_alu,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_etc,
  output logic [CNT_W-1:0] cnt_words
);

  op_class_t cls;

  assign cls = classify(opcode);

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_alu    <= '0;
      cnt_load   <= '0;
      cnt_store  <= '0;
      cnt_branch <= '0;
      cnt_etc    <= '0;
      cnt_words  <= '0;
    end else if (en) begin
      cnt_words <= sat_inc(cnt_words);
      case (cls)
        CL_ALU:    cnt_alu    <= sat_inc(cnt_alu);
        CL_LOAD:   cnt_load   <= sat_inc(cnt_load);
        CL_STORE:  cnt_store  <= sat_inc(cnt_store);
        CL_BRANCH: cnt_branch <= sat_inc(cnt_branch);
        CL_ETC:    cnt_etc    <= sat_inc(cnt_etc);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tcm_inst_loader.sv
// Streams a program into the TCM, profiles it, pulses
// core reset and measures cycles until the halt fetch.
module tcm_inst_loader
  import tcm_loader_pkg::*;
#(
  parameter int          TRACE_SIZE  = 200,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] HALT_INST   = 32'h0000_8067,
  parameter int          EXEC_OFFSET = 4,
  parameter int          MAX_RUN     = 65535
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             inst_valid_i,
  input  logic [31:0]      inst_data_i,
  input  logic             inst_last_i,
  output logic             inst_ready_o,
  output logic [3:0]       tb_inst_we_o,
  output logic [31:0]      tb_inst_addr_o,
  output logic [31:0]      tb_inst_data_o,
  output logic             rst_cpu_o,
  input  logic [31:0]      fetch_inst_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cnt_alu_o,
  output logic [CNT_W-1:0] cnt_load_o,
  output logic [CNT_W-1:0] cnt_store_o,
  output logic [CNT_W-1:0] cnt_branch_o,
  output logic [CNT_W-1:0] cnt_etc_o,
  output logic [CNT_W-1:0] cnt_words_o,
  output logic [CNT_W-1:0] exec_cycles_o
);

  localparam int IDX_W = $clog2(TRACE_SIZE + 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W:0]   halt_sum;
  logic             hs;
  logic             clr;
  logic             last_word;
  logic             is_halt;
  logic             at_max;

  assign hs = inst_valid_i & inst_ready_o;
  assign clr = start_i &
               (state == S_IDLE || state == S_DONE);
  assign last_word = inst_last_i ||
                     (idx == IDX_W'(TRACE_SIZE - 1));
  assign is_halt = (fetch_inst_i == HALT_INST);
  assign at_max = (run_cnt == CNT_W'(MAX_RUN));
  // one extra bit so the drain offset saturates cleanly
  assign halt_sum = {1'b0, run_cnt} +
                    (CNT_W + 1)'(EXEC_OFFSET);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      idx            <= '0;
      run_cnt        <= '0;
      inst_ready_o   <= 1'b0;
      tb_inst_we_o   <= '0;
      tb_inst_addr_o <= '0;
      tb_inst_data_o <= '0;
      rst_cpu_o      <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      timeout_o      <= 1'b0;
      exec_cycles_o  <= '0;
    end else begin
      tb_inst_we_o <= '0;
      rst_cpu_o    <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state         <= S_LOAD;
            idx           <= '0;
            inst_ready_o  <= 1'b1;
            busy_o        <= 1'b1;
            done_o        <= 1'b0;
            timeout_o     <= 1'b0;
            exec_cycles_o <= '0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            tb_inst_we_o   <= 4'hf;
            tb_inst_addr_o <= BASE_ADDR +
                              (32'(idx) << 2);
            tb_inst_data_o <= inst_data_i;
            idx            <= idx + 1'b1;
            if (last_word) begin
              state        <= S_GAP;
              inst_ready_o <= 1'b0;
            end
          end
        end
        S_GAP: state <= S_CRST;
        S_CRST: begin
          rst_cpu_o <= 1'b1;
          run_cnt   <= '0;
          state     <= S_RUN;
        end
        S_RUN: begin
          if (is_halt) begin
            exec_cycles_o <= halt_sum[CNT_W] ?
                             '1 : halt_sum[CNT_W-1:0];
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (at_max) begin
            timeout_o     <= 1'b1;
            exec_cycles_o <= CNT_W'(MAX_RUN);
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (!(&run_cnt)) begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  tcm_inst_profiler #(
    .CNT_W(CNT_W)
  ) u_prof (
    .clk        (clk_i),
    .rst        (rst_i),
    .clr        (clr),
    .en         (hs),
    .opcode     (inst_data_i[6:0]),
    .cnt_alu    (cnt_alu_o),
    .cnt_load   (cnt_load_o),
    .cnt_store  (cnt_store_o),
    .cnt_branch (cnt_branch_o),
    .cnt_etc    (cnt_etc_o),
    .cnt_words  (cnt_words_o)
  );

endmodule

// File: tb/tb_tcm_inst_loader.sv
// Scoreboard bench for tcm_inst_loader: expected TCM
// writes are queued at handshake and matched on write.
module tb_tcm_inst_loader;

  localparam logic [31:0] HALT = 32'h0000_8067;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] data = '0;
  logic        last = 1'b0;
  logic [31:0] fetch = '0;
  logic        ready;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rst_cpu;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] c_alu, c_load, c_store;
  logic [15:0] c_branch, c_etc, c_words;
  logic [15:0] exec;

  always #5 clk = ~clk;

  tcm_inst_loader #(
    .TRACE_SIZE(4),
    .MAX_RUN(10)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .inst_valid_i   (valid),
    .inst_data_i    (data),
    .inst_last_i    (last),
    .inst_ready_o   (ready),
    .tb_inst_we_o   (we),
    .tb_inst_addr_o (addr),
    .tb_inst_data_o (wdata),
    .rst_cpu_o      (rst_cpu),
    .fetch_inst_i   (fetch),
    .busy_o         (busy),
    .done_o         (done),
    .timeout_o      (timeout),
    .cnt_alu_o      (c_alu),
    .cnt_load_o     (c_load),
    .cnt_store_o    (c_store),
    .cnt_branch_o   (c_branch),
    .cnt_etc_o      (c_etc),
    .cnt_words_o    (c_words),
    .exec_cycles_o  (exec)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t q[$];
  wr_t ew;
  int  wr_cyc[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  wr_count = 0;
  int  exp_idx = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (we !== 4'h0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h",
                 addr, wdata);
      end else begin
        ew = q.pop_front();
        if (we !== 4'hf || addr !== ew.addr ||
            wdata !== ew.data) begin
          errors++;
          $display("FAIL write got we=%h a=%h d=%h exp a=%h d=%h",
                   we, addr, wdata, ew.addr, ew.data);
        end
      end
      wr_count++;
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic offer(input logic [31:0] d,
                       input logic l,
                       input int max_wait,
                       output bit acc);
    wr_t w;
    acc = 1'b0;
    valid = 1'b1;
    data = d;
    last = l;
    for (int i = 0; i <= max_wait && !acc; i++) begin
      if (ready === 1'b1) begin
        w.addr = 32'(exp_idx * 4);
        w.data = d;
        q.push_back(w);
        exp_idx++;
        acc = 1'b1;
        @(posedge clk);
      end
      @(negedge clk);
    end
  endtask

  task automatic start_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_idx = 0;
  endtask

  task automatic wait_rst(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (rst_cpu === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || we !== 4'h0) begin
      errors++;
      $display("FAIL reset_port ready=%b we=%h exp 0 0",
               ready, we);
    end
    checks++;
    if (rst_cpu !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags rc=%b b=%b d=%b t=%b exp 0",
               rst_cpu, busy, done, timeout);
    end
    checks++;
    if (c_words !== 16'd0 || c_alu !== 16'd0 ||
        exec !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt words=%0d alu=%0d exec=%0d exp 0",
               c_words, c_alu, exec);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load3();
    bit a0, a1, a2, seen;
    int rc;
    start_session();
    checks++;
    if (ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load3_start ready=%b busy=%b exp 1 1",
               ready, busy);
    end
    wr_cyc.delete();
    offer(32'h0050_0093, 1'b0, 5, a0);
    offer(32'h0030_2023, 1'b0, 5, a1);
    offer(32'h0000_8067, 1'b1, 5, a2);
    valid = 1'b0;
    last = 1'b0;
    wait_rst(seen);
    rc = cyc;
    checks++;
    if (!(a0 && a1 && a2) || !seen) begin
      errors++;
      $display("FAIL load3_flow acc=%b%b%b rst_seen=%b exp 1111",
               a0, a1, a2, seen);
    end
    checks++;
    if (wr_cyc.size() != 3) begin
      errors++;
      $display("FAIL load3_nwr got %0d exp 3", wr_cyc.size());
    end else begin
      checks++;
      if (wr_cyc[1] != wr_cyc[0] + 1 ||
          wr_cyc[2] != wr_cyc[1] + 1) begin
        errors++;
        $display("FAIL load3_b2b cycles %0d %0d %0d exp consecutive",
                 wr_cyc[0], wr_cyc[1], wr_cyc[2]);
      end
      checks++;
      if (rc - wr_cyc[2] != 2) begin
        errors++;
        $display("FAIL load3_rst_lat got %0d exp 2",
                 rc - wr_cyc[2]);
      end
    end
    checks++;
    if (c_alu !== 16'd1 || c_store !== 16'd1 ||
        c_etc !== 16'd1 || c_load !== 16'd0 ||
        c_branch !== 16'd0 || c_words !== 16'd3) begin
      errors++;
      $display("FAIL load3_cnt a=%0d l=%0d s=%0d b=%0d e=%0d w=%0d exp 1 0 1 0 1 3",
               c_alu, c_load, c_store, c_branch, c_etc, c_words);
    end
  endtask

  task automatic test_halt();
    @(negedge clk);
    checks++;
    if (rst_cpu !== 1'b0) begin
      errors++;
      $display("FAIL halt_rst_width rst_cpu=%b exp 0", rst_cpu);
    end
    repeat (6) @(negedge clk);
    fetch = HALT;
    @(negedge clk);
    fetch = '0;
    checks++;
    if (exec !== 16'd11 || done !== 1'b1 ||
        timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL halt7 exec=%0d d=%b t=%b b=%b exp 11 1 0 0",
               exec, done, timeout, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exec !== 16'd11 || c_words !== 16'd3 ||
        done !== 1'b1) begin
      errors++;
      $display("FAIL done_hold exec=%0d words=%0d d=%b exp 11 3 1",
               exec, c_words, done);
    end
  endtask

  task automatic test_toggle_timeout();
    bit a0, a1, seen;
    int base;
    base = wr_count;
    start_session();
    checks++;
    if (timeout !== 1'b0 || exec !== 16'd0 ||
        done !== 1'b0 || c_words !== 16'd0) begin
      errors++;
      $display("FAIL restart_clear t=%b e=%0d d=%b w=%0d exp 0",
               timeout, exec, done, c_words);
    end
    offer(32'h0010_0113, 1'b0, 5, a0);
    valid = 1'b0;
    @(negedge clk);
    checks++;
    if (we !== 4'h0) begin
      errors++;
      $display("FAIL toggle_gap we=%h exp 0", we);
    end
    offer(32'h0020_8463, 1'b1, 5, a1);
    valid = 1'b0;
    last = 1'b0;
    wait_rst(seen);
    checks++;
    if (!(a0 && a1 && seen) || wr_count - base != 2) begin
      errors++;
      $display("FAIL toggle_wr acc=%b%b seen=%b n=%0d exp 111 2",
               a0, a1, seen, wr_count - base);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early done=%b exp 0", done);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1 || exec !== 16'd10 ||
        done !== 1'b1) begin
      errors++;
      $display("FAIL timeout t=%b exec=%0d d=%b exp 1 10 1",
               timeout, exec, done);
    end
    checks++;
    if (c_alu !== 16'd1 || c_branch !== 16'd1 ||
        c_words !== 16'd2) begin
      errors++;
      $display("FAIL toggle_cnt a=%0d b=%0d w=%0d exp 1 1 2",
               c_alu, c_branch, c_words);
    end
  endtask

  task automatic test_halt_at_max();
    bit a0, seen;
    start_session();
    offer(HALT, 1'b1, 5, a0);
    valid = 1'b0;
    last = 1'b0;
    wait_rst(seen);
    repeat (10) @(negedge clk);
    fetch = HALT;
    @(negedge clk);
    fetch = '0;
    checks++;
    if (!(a0 && seen) || exec !== 16'd14 ||
        timeout !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL halt_max acc=%b seen=%b exec=%0d t=%b d=%b exp 1 1 14 0 1",
               a0, seen, exec, timeout, done);
    end
    checks++;
    if (c_words !== 16'd1 || c_etc !== 16'd1) begin
      errors++;
      $display("FAIL one_word w=%0d e=%0d exp 1 1",
               c_words, c_etc);
    end
  endtask

  task automatic test_trace_limit();
    logic [31:0] w [6];
    bit acc;
    int nacc;
    int base;
    bit seen;
    w[0] = 32'h0000_a103;
    w[1] = 32'h0020_8063;
    w[2] = 32'h1234_50b7;
    w[3] = 32'h0000_007f;
    w[4] = 32'h0050_0093;
    w[5] = 32'h0030_2023;
    nacc = 0;
    base = wr_count;
    start_session();
    for (int i = 0; i < 6; i++) begin
      offer(w[i], 1'b0, (i < 4) ? 3 : 2, acc);
      if (acc) nacc++;
      if (i == 3) begin
        checks++;
        if (ready !== 1'b0) begin
          errors++;
          $display("FAIL limit_ready ready=%b exp 0", ready);
        end
      end
    end
    valid = 1'b0;
    checks++;
    if (nacc != 4 || wr_count - base != 4) begin
      errors++;
      $display("FAIL limit_acc acc=%0d wr=%0d exp 4 4",
               nacc, wr_count - base);
    end
    checks++;
    if (c_words !== 16'd4 || c_load !== 16'd1 ||
        c_branch !== 16'd1 || c_etc !== 16'd1 ||
        c_alu !== 16'd0 || c_store !== 16'd0) begin
      errors++;
      $display("FAIL limit_cnt w=%0d l=%0d b=%0d e=%0d a=%0d s=%0d exp 4 1 1 1 0 0",
               c_words, c_load, c_branch, c_etc, c_alu, c_store);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen || timeout !== 1'b1) begin
      errors++;
      $display("FAIL limit_done seen=%b t=%b exp 1 1",
               seen, timeout);
    end
  endtask

  task automatic test_reset_midload();
    bit a0, a1, a2, seen;
    start_session();
    offer(32'h0050_0093, 1'b0, 5, a0);
    offer(32'h0030_2023, 1'b0, 5, a1);
    data = 32'h0000_0013;
    valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    rst = 1'b0;
    checks++;
    if (we !== 4'h0 || ready !== 1'b0 ||
        rst_cpu !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_port we=%h r=%b rc=%b b=%b exp 0",
               we, ready, rst_cpu, busy);
    end
    checks++;
    if (c_words !== 16'd0 || c_alu !== 16'd0 ||
        c_store !== 16'd0 || !(a0 && a1)) begin
      errors++;
      $display("FAIL midrst_cnt w=%0d a=%0d s=%0d acc=%b%b exp 0 0 0 11",
               c_words, c_alu, c_store, a0, a1);
    end
    @(negedge clk);
    start_session();
    offer(HALT, 1'b1, 5, a2);
    valid = 1'b0;
    last = 1'b0;
    wait_rst(seen);
    fetch = HALT;
    @(negedge clk);
    fetch = '0;
    checks++;
    if (!(a2 && seen) || exec !== 16'd4 ||
        c_words !== 16'd1 || done !== 1'b1) begin
      errors++;
      $display("FAIL reload acc=%b seen=%b exec=%0d w=%0d d=%b exp 1 1 4 1 1",
               a2, seen, exec, c_words, done);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_load3();
    test_halt();
    test_toggle_timeout();
    test_halt_at_max();
    test_trace_limit();
    test_reset_midload();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_writes left=%0d exp 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
